// File: rtl/bp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : bp_pkg
// Brief  : Shared types, counter encodings and helpers for the branch
//          predictor (BTB + 2-bit saturating counters).
// Rev    : 1.0  initial release
// ============================================================================
package bp_pkg;

    // 2-bit saturating counter encoding; bit 1 is the taken prediction
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Sequencer states: INIT sweeps the table, RUN predicts and trains
    typedef enum logic [0:0] {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    // Next counter value after a resolved outcome, saturating at both ends
    function automatic logic [1:0] sat2_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_btb_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : bp_btb_ram
// Brief  : Direct-mapped BTB storage: valid, tag, target and 2-bit counter
//          per entry. Asynchronous lookup port, synchronous train port that
//          does its own hit/allocate decision, and a valid-clear port used
//          by the init sweep.
// Rev    : 1.0  initial release
// ============================================================================
module bp_btb_ram
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int IDX_W   = 6,
    parameter int TAG_W   = 24
) (
    input  logic              clk_i,
    // lookup port
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [ADDR_W-1:0] rd_target_o,
    output logic [1:0]        rd_ctr_o,
    // train port
    input  logic              upd_en_i,
    input  logic [IDX_W-1:0]  upd_idx_i,
    input  logic [TAG_W-1:0]  upd_tag_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    // sweep clear port
    input  logic              clr_en_i,
    input  logic [IDX_W-1:0]  clr_idx_i
);

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic [ADDR_W-1:0] r_target [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];

    logic w_upd_hit;

    // Lookup reads are combinational so the prediction is zero-latency
    assign rd_valid_o  = r_valid[rd_idx_i];
    assign rd_tag_o    = r_tag[rd_idx_i];
    assign rd_target_o = r_target[rd_idx_i];
    assign rd_ctr_o    = r_ctr[rd_idx_i];

    assign w_upd_hit = r_valid[upd_idx_i] && (r_tag[upd_idx_i] == upd_tag_i);

    // Table write: sweep clear wins; otherwise train a hit or allocate on a taken miss
    always_ff @(posedge clk_i) begin
        if (clr_en_i) begin
            r_valid[clr_idx_i] <= 1'b0;
            r_ctr[clr_idx_i]   <= CTR_WNT;
        end else if (upd_en_i) begin
            if (w_upd_hit) begin
                r_ctr[upd_idx_i] <= sat2_next(r_ctr[upd_idx_i], upd_taken_i);
                if (upd_taken_i) begin
                    r_target[upd_idx_i] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                r_valid[upd_idx_i]  <= 1'b1;
                r_tag[upd_idx_i]    <= upd_tag_i;
                r_target[upd_idx_i] <= upd_target_i;
                r_ctr[upd_idx_i]    <= CTR_WT;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : branch_predictor
// Brief  : Dynamic branch predictor for the 5-stage pipeline. IF-stage
//          zero-latency BTB lookup, ID-stage training and mispredict flag,
//          init/clear sweep sequencing and saturating statistics.
// Rev    : 1.0  initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    output logic              mispredict_o,
    output logic [CNT_W-1:0]  stat_branches_o,
    output logic [CNT_W-1:0]  stat_mispred_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    localparam logic [ADDR_W-1:0] c_pc_step  = ADDR_W'(4);
    localparam logic [IDX_W-1:0]  c_last_idx = IDX_W'(ENTRIES - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    bp_state_e         r_state;
    bp_state_e         w_state_nxt;
    logic [IDX_W-1:0]  r_sweep;
    logic [IDX_W-1:0]  w_sweep_nxt;
    logic              w_sweep_clr;

    logic [CNT_W-1:0]  r_stat_branches;
    logic [CNT_W-1:0]  r_stat_mispred;

    logic              w_rd_valid;
    logic [TAG_W-1:0]  w_rd_tag;
    logic [ADDR_W-1:0] w_rd_target;
    logic [1:0]        w_rd_ctr;
    logic              w_hit;
    logic              w_train;
    logic              w_unused_pc_lsbs;

    // Word-offset bits never take part in indexing or tagging
    assign w_unused_pc_lsbs = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

    bp_btb_ram #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .IDX_W   (IDX_W),
        .TAG_W   (TAG_W)
    ) u_btb (
        .clk_i        (clk_i),
        .rd_idx_i     (lookup_pc_i[IDX_W+1:2]),
        .rd_valid_o   (w_rd_valid),
        .rd_tag_o     (w_rd_tag),
        .rd_target_o  (w_rd_target),
        .rd_ctr_o     (w_rd_ctr),
        .upd_en_i     (w_train),
        .upd_idx_i    (upd_pc_i[IDX_W+1:2]),
        .upd_tag_i    (upd_pc_i[ADDR_W-1:IDX_W+2]),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i),
        .clr_en_i     (w_sweep_clr),
        .clr_idx_i    (r_sweep)
    );

    // Sequencer state register; reset restarts the sweep from entry 0
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= BP_INIT;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    // Next-state: sweep one entry per cycle, clear_i restarts the sweep
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        w_sweep_clr = 1'b0;
        case (r_state)
            BP_INIT: begin
                w_sweep_clr = 1'b1;
                if (clear_i) begin
                    w_sweep_nxt = '0;
                end else if (r_sweep == c_last_idx) begin
                    w_state_nxt = BP_RUN;
                    w_sweep_nxt = '0;
                end else begin
                    w_sweep_nxt = r_sweep + IDX_W'(1);
                end
            end
            BP_RUN: begin
                if (clear_i) begin
                    w_state_nxt = BP_INIT;
                    w_sweep_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = BP_INIT;
                w_sweep_nxt = '0;
            end
        endcase
    end

    assign ready_o = (r_state == BP_RUN);
    assign w_train = ready_o && upd_valid_i;

    // Lookup: a taken prediction needs a valid tag match with counter bit 1 set
    assign w_hit         = ready_o && w_rd_valid && (w_rd_tag == lookup_pc_i[ADDR_W-1:IDX_W+2]);
    assign pred_taken_o  = w_hit && w_rd_ctr[1];
    assign pred_target_o = pred_taken_o ? w_rd_target : (lookup_pc_i + c_pc_step);

    // Direction wrong, or taken with the wrong target
    assign mispredict_o = w_train &&
                          ((upd_taken_i != upd_pred_taken_i) ||
                           (upd_taken_i && (upd_target_i != upd_pred_target_i)));

    // Statistics: saturating counters, cleared only by rst_i
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_branches <= '0;
            r_stat_mispred  <= '0;
        end else if (w_train) begin
            if (r_stat_branches != c_cnt_max) r_stat_branches <= r_stat_branches + CNT_W'(1);
            if (mispredict_o && (r_stat_mispred != c_cnt_max)) r_stat_mispred <= r_stat_mispred + CNT_W'(1);
        end
    end

    assign stat_branches_o = r_stat_branches;
    assign stat_mispred_o  = r_stat_mispred;

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_branch_predictor
// Brief  : Self-checking bench for branch_predictor with a word-address
//          keyed reference table, directed scenarios and random traffic.
// Rev    : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              clear_i;
    logic              ready_o;
    logic [ADDR_W-1:0] lookup_pc_i;
    logic              pred_taken_o;
    logic [ADDR_W-1:0] pred_target_o;
    logic              upd_valid_i;
    logic [ADDR_W-1:0] upd_pc_i;
    logic              upd_taken_i;
    logic [ADDR_W-1:0] upd_target_i;
    logic              upd_pred_taken_i;
    logic [ADDR_W-1:0] upd_pred_target_i;
    logic              mispredict_o;
    logic [CNT_W-1:0]  stat_branches_o;
    logic [CNT_W-1:0]  stat_mispred_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: entries keyed by full word address (pc >> 2)
    bit                m_valid  [ENTRIES];
    logic [ADDR_W-1:0] m_key    [ENTRIES];
    logic [ADDR_W-1:0] m_target [ENTRIES];
    int                m_ctr    [ENTRIES];
    int                m_left;
    bit                m_ready;
    int                m_br;
    int                m_mp;

    always #5 clk_i = ~clk_i;

    branch_predictor #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .clear_i           (clear_i),
        .ready_o           (ready_o),
        .lookup_pc_i       (lookup_pc_i),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .upd_pred_taken_i  (upd_pred_taken_i),
        .upd_pred_target_i (upd_pred_target_i),
        .mispredict_o      (mispredict_o),
        .stat_branches_o   (stat_branches_o),
        .stat_mispred_o    (stat_mispred_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int slot(input logic [ADDR_W-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [ADDR_W-1:0] pc);
        int s;
        s = slot(pc);
        return m_ready && m_valid[s] && (m_key[s] == (pc >> 2));
    endfunction

    function automatic bit m_pred_taken(input logic [ADDR_W-1:0] pc);
        return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
    endfunction

    function automatic logic [ADDR_W-1:0] m_pred_target(input logic [ADDR_W-1:0] pc);
        logic [ADDR_W-1:0] t;
        t = pc + 32'd4;
        if (m_pred_taken(pc)) t = m_target[slot(pc)];
        return t;
    endfunction

    function automatic bit m_mispredict();
        return upd_valid_i && m_ready &&
               ((upd_taken_i != upd_pred_taken_i) ||
                (upd_taken_i && (upd_target_i != upd_pred_target_i)));
    endfunction

    task automatic m_invalidate();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs presented at it
    task automatic m_step();
        bit mis;
        int s;
        if (rst_i) begin
            m_invalidate();
            m_left  = ENTRIES;
            m_ready = 1'b0;
            m_br    = 0;
            m_mp    = 0;
        end else begin
            mis = m_mispredict();
            if (m_ready && upd_valid_i) begin
                if (m_br < CNT_MAX) m_br++;
                if (mis && m_mp < CNT_MAX) m_mp++;
                s = slot(upd_pc_i);
                if (m_hit(upd_pc_i)) begin
                    if (upd_taken_i) begin
                        if (m_ctr[s] < 3) m_ctr[s]++;
                        m_target[s] = upd_target_i;
                    end else if (m_ctr[s] > 0) begin
                        m_ctr[s]--;
                    end
                end else if (upd_taken_i) begin
                    m_valid[s]  = 1'b1;
                    m_key[s]    = upd_pc_i >> 2;
                    m_target[s] = upd_target_i;
                    m_ctr[s]    = 2;
                end
            end
            if (clear_i) begin
                m_invalidate();
                m_left  = ENTRIES;
                m_ready = 1'b0;
            end else if (!m_ready) begin
                m_left--;
                if (m_left == 0) m_ready = 1'b1;
            end
        end
    endtask

    // Compare all outputs against the model, then take one clock edge
    task automatic cycle();
        #2;
        chk("ready", 64'(ready_o), 64'(m_ready));
        chk("pred_taken", 64'(pred_taken_o), 64'(m_pred_taken(lookup_pc_i)));
        chk("pred_target", 64'(pred_target_o), 64'(m_pred_target(lookup_pc_i)));
        chk("mispredict", 64'(mispredict_o), 64'(m_mispredict()));
        chk("stat_branches", 64'(stat_branches_o), 64'(m_br));
        chk("stat_mispred", 64'(stat_mispred_o), 64'(m_mp));
        @(posedge clk_i);
        m_step();
        #1;
    endtask

    task automatic set_upd(input logic v, input logic [ADDR_W-1:0] pc, input logic tk,
                           input logic [ADDR_W-1:0] tgt, input logic ptk,
                           input logic [ADDR_W-1:0] ptgt);
        upd_valid_i       = v;
        upd_pc_i          = pc;
        upd_taken_i       = tk;
        upd_target_i      = tgt;
        upd_pred_taken_i  = ptk;
        upd_pred_target_i = ptgt;
    endtask

    function automatic logic [ADDR_W-1:0] rand_pc();
        logic [ADDR_W-1:0] pc;
        pc = (ADDR_W'($urandom_range(0, 2)) << 8) | (ADDR_W'($urandom_range(0, 7)) << 2);
        pc = pc | ADDR_W'($urandom_range(0, 3));
        return pc;
    endfunction

    initial begin
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        lookup_pc_i = '0;
        set_upd(1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(posedge clk_i);
        m_step();
        #1;
        cycle();
        cycle();

        // Init sweep: not ready for exactly ENTRIES cycles, pc+4 fallthrough
        rst_i = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            lookup_pc_i = (i == 0) ? 32'hFFFF_FFFC : $urandom;
            upd_valid_i = (i % 3 == 0);
            upd_taken_i = 1'b1;
            #1;
            chk("init_not_ready", 64'(ready_o), 64'd0);
            if (i == 0) chk("init_wrap_target", 64'(pred_target_o), 64'd0);
            cycle();
        end
        upd_valid_i = 1'b0;
        #1;
        chk("ready_after_init", 64'(ready_o), 64'd1);

        // Allocate on a taken miss: mispredict, then predicted taken next cycle
        lookup_pc_i = 32'h40;
        set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
        #1;
        chk("alloc_mispredict", 64'(mispredict_o), 64'd1);
        chk("alloc_same_cycle", 64'(pred_taken_o), 64'd0);
        cycle();
        chk("alloc_mispred_count", 64'(stat_mispred_o), 64'd1);
        upd_valid_i = 1'b0;
        #1;
        chk("alloc_hit_taken", 64'(pred_taken_o), 64'd1);
        chk("alloc_hit_target", 64'(pred_target_o), 64'h100);
        cycle();

        // Three not-taken from weak-T: not-taken after the first, saturate at 00
        for (int k = 0; k < 3; k++) begin
            set_upd(1'b1, 32'h40, 1'b0, 32'h44, (k == 0), 32'h100);
            cycle();
            upd_valid_i = 1'b0;
            #1;
            chk($sformatf("nt_train_%0d", k), 64'(pred_taken_o), 64'd0);
            cycle();
        end
        // From strong-NT two taken outcomes are needed to predict taken
        for (int k = 0; k < 2; k++) begin
            set_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
            cycle();
            upd_valid_i = 1'b0;
            #1;
            chk($sformatf("t_train_%0d", k), 64'(pred_taken_o), 64'(k == 1));
            cycle();
        end

        // Alias: same index, different tag
        lookup_pc_i = 32'h40 + 32'(4 * ENTRIES);
        #1;
        chk("alias_miss", 64'(pred_taken_o), 64'd0);
        chk("alias_target", 64'(pred_target_o), 64'(32'h40 + 32'(4 * ENTRIES) + 32'd4));
        cycle();

        // Same-cycle update and lookup see pre-update contents
        lookup_pc_i = 32'h80;
        set_upd(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
        #1;
        chk("same_cycle_old", 64'(pred_taken_o), 64'd0);
        cycle();
        upd_valid_i = 1'b0;
        #1;
        chk("same_cycle_new", 64'(pred_taken_o), 64'd1);
        chk("same_cycle_target", 64'(pred_target_o), 64'h200);
        cycle();

        // Twenty mispredicts saturate the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            set_upd(1'b1, 32'h400 + 32'(4 * i), 1'b1, 32'h800, 1'b0, 32'h0);
            cycle();
        end
        upd_valid_i = 1'b0;
        #1;
        chk("mispred_sat", 64'(stat_mispred_o), 64'd15);
        chk("branches_sat", 64'(stat_branches_o), 64'd15);

        // Clear in RUN: sweep again, everything misses, stats retained
        clear_i = 1'b1;
        cycle();
        clear_i = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            lookup_pc_i = 32'h40;
            #1;
            chk("clear_not_ready", 64'(ready_o), 64'd0);
            cycle();
        end
        #1;
        chk("ready_after_clear", 64'(ready_o), 64'd1);
        chk("clear_miss_40", 64'(pred_taken_o), 64'd0);
        chk("clear_stats_kept", 64'(stat_mispred_o), 64'd15);
        lookup_pc_i = 32'h80;
        cycle();

        // Fresh counters for random traffic
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst_i       = ($urandom_range(0, 399) == 0);
            clear_i     = ($urandom_range(0, 149) == 0);
            lookup_pc_i = rand_pc();
            upd_valid_i = ($urandom_range(0, 9) < 7);
            upd_pc_i    = ($urandom_range(0, 3) == 0) ? lookup_pc_i : rand_pc();
            upd_taken_i = $urandom_range(0, 1);
            upd_target_i = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            upd_pred_taken_i = $urandom_range(0, 1);
            upd_pred_target_i = ($urandom_range(0, 1) == 1) ? upd_target_i : 32'h1000;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
